// File: rtl/huffman_pkg.sv
// Shared constants and state type for the Huffman bit packer.
package huffman_pkg;

    localparam int MAX_CODE_BITS = 18;
    localparam int BUF_BITS      = 32;
    localparam int ACCEPT_LIMIT  = 14;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/huffman_bit_packer.sv
// Packs variable-length Huffman codes MSB-first into a byte stream, with
// flush/pad handling for the final partial byte.
module huffman_bit_packer
    import huffman_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [MAX_CODE_BITS-1:0] data_in,
    input  logic [4:0]               valid_bits,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     flush_done,
    output logic [15:0]              byte_count,
    output logic                     len_error
);

    state_t                     state;
    logic [BUF_BITS-1:0]        bit_buf;
    logic [5:0]                 fill;

    logic                       transfer;
    logic                       accept;
    logic                       len_bad;
    logic [5:0]                 drained;
    logic [5:0]                 fill_after;
    logic [5:0]                 fill_next;
    logic [BUF_BITS-1:0]        buf_after;
    logic [BUF_BITS-1:0]        appended;
    logic [MAX_CODE_BITS-1:0]   rev_code;
    logic [4:0]                 src_idx;

    always_comb begin
        in_ready   = (state == RUN) && (fill <= 6'(ACCEPT_LIMIT));
        out_valid  = (fill >= 6'd8) || ((state == FLUSH) && (fill != 6'd0));
        out_last   = (state == FLUSH) && (fill != 6'd0) && (fill <= 6'd8);
        out_data   = bit_buf[7:0];
        transfer   = out_valid && out_ready;
        len_bad    = valid_bits > 5'(MAX_CODE_BITS);
        accept     = in_ready && (valid_bits != 5'd0) && !len_bad;

        drained    = 6'd0;
        if (transfer) begin
            drained = (fill >= 6'd8) ? 6'd8 : fill;
        end
        fill_after = fill - drained;
        buf_after  = transfer ? (bit_buf >> 8) : bit_buf;

        // Bit-reverse the valid code bits so the code MSB lands at the lowest free position.
        rev_code = '0;
        src_idx  = '0;
        for (int i = 0; i < MAX_CODE_BITS; i++) begin
            if (5'(i) < valid_bits) begin
                src_idx     = valid_bits - 5'(i) - 5'd1;
                rev_code[i] = data_in[src_idx];
            end
        end
        appended  = {{(BUF_BITS-MAX_CODE_BITS){1'b0}}, rev_code} << fill_after;
        fill_next = fill_after + (accept ? {1'b0, valid_bits} : 6'd0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            bit_buf    <= '0;
            fill       <= 6'd0;
            byte_count <= 16'd0;
            len_error  <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            bit_buf    <= accept ? (buf_after | appended) : buf_after;
            fill       <= fill_next;
            if (transfer) begin
                byte_count <= byte_count + 16'd1;
            end
            if (len_bad) begin
                len_error <= 1'b1;
            end
            // No words are accepted in FLUSH, so a byte with fill <= 8 is always the last one.
            case (state)
                RUN: begin
                    if (flush) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if ((fill == 6'd0) || (transfer && (fill <= 6'd8))) begin
                        state      <= RUN;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed self-checking bench for huffman_bit_packer with hand-computed bytes.
module tb_huffman_bit_packer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [17:0] data_in = '0;
    logic [4:0]  valid_bits = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        flush_done;
    logic [15:0] byte_count;
    logic        len_error;

    int check_count = 0;
    int fail_count  = 0;

    huffman_bit_packer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .valid_bits (valid_bits),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .flush_done (flush_done),
        .byte_count (byte_count),
        .len_error  (len_error)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one word/flush for a single clock edge, then idle the inputs.
    task automatic applyStimulus(input logic [17:0] d, input logic [4:0] vb, input logic fl);
        data_in    = d;
        valid_bits = vb;
        flush      = fl;
        tick();
        data_in    = '0;
        valid_bits = '0;
        flush      = 1'b0;
    endtask

    initial begin
        #3;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_flush_done", flush_done, 0);
        checkOutput("rst_byte_count", byte_count, 0);
        checkOutput("rst_len_error", len_error, 0);
        #9 reset_n = 1'b1;
        tick();
        checkOutput("post_rst_in_ready", in_ready, 1);

        // Single 8-bit code
        out_ready = 1'b1;
        applyStimulus(18'h00030, 5'd8, 1'b0);
        checkOutput("b8_valid", out_valid, 1);
        checkOutput("b8_data", out_data, 8'h0C);
        checkOutput("b8_last", out_last, 0);
        tick();
        checkOutput("b8_count", byte_count, 1);
        checkOutput("b8_drained", out_valid, 0);

        // Two 5-bit codes then flush
        applyStimulus(18'h00015, 5'd5, 1'b0);
        checkOutput("f5_partial_valid", out_valid, 0);
        applyStimulus(18'h0001F, 5'd5, 1'b0);
        checkOutput("f5_data", out_data, 8'hF5);
        checkOutput("f5_last", out_last, 0);
        applyStimulus(18'h0, 5'd0, 1'b1);
        checkOutput("f5_tail_valid", out_valid, 1);
        checkOutput("f5_tail_data", out_data, 8'h03);
        checkOutput("f5_tail_last", out_last, 1);
        checkOutput("f5_flush_in_ready", in_ready, 0);
        tick();
        checkOutput("f5_flush_done", flush_done, 1);
        checkOutput("f5_done_valid", out_valid, 0);
        checkOutput("f5_count", byte_count, 3);
        tick();
        checkOutput("f5_done_pulse", flush_done, 0);

        // Backpressure with 18-bit codes
        out_ready = 1'b0;
        applyStimulus(18'h3FFFF, 5'd18, 1'b0);
        checkOutput("bp_in_ready", in_ready, 0);
        checkOutput("bp_data0", out_data, 8'hFF);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(18'h20001, 5'd18, 1'b0);
            checkOutput("bp_hold_ready", in_ready, 0);
            checkOutput("bp_hold_valid", out_valid, 1);
            checkOutput("bp_hold_data", out_data, 8'hFF);
        end
        checkOutput("bp_hold_count", byte_count, 3);
        out_ready = 1'b1;
        applyStimulus(18'h20001, 5'd18, 1'b0);
        checkOutput("bp_ready_after_drain", in_ready, 1);
        checkOutput("bp_data1", out_data, 8'hFF);
        applyStimulus(18'h20001, 5'd18, 1'b0);
        checkOutput("bp_data2", out_data, 8'h07);
        checkOutput("bp_full_ready", in_ready, 0);
        applyStimulus(18'h0, 5'd0, 1'b1);
        checkOutput("bp_data3", out_data, 8'h00);
        checkOutput("bp_data3_valid", out_valid, 1);
        checkOutput("bp_data3_last", out_last, 0);
        tick();
        checkOutput("bp_data4", out_data, 8'h08);
        checkOutput("bp_data4_last", out_last, 1);
        tick();
        checkOutput("bp_flush_done", flush_done, 1);
        checkOutput("bp_count", byte_count, 8);
        tick();

        // Illegal length is dropped and flagged
        out_ready = 1'b0;
        applyStimulus(18'h00006, 5'd3, 1'b0);
        applyStimulus(18'h3FFFF, 5'd20, 1'b0);
        checkOutput("len_err_set", len_error, 1);
        checkOutput("len_err_valid", out_valid, 0);
        applyStimulus(18'h00001, 5'd5, 1'b0);
        checkOutput("len_err_next_valid", out_valid, 1);
        checkOutput("len_err_next_data", out_data, 8'h83);
        out_ready = 1'b1;
        tick();
        checkOutput("len_err_count", byte_count, 9);
        checkOutput("len_err_sticky", len_error, 1);

        // Flush with an empty buffer
        applyStimulus(18'h0, 5'd0, 1'b1);
        checkOutput("empty_flush_valid", out_valid, 0);
        checkOutput("empty_flush_done_early", flush_done, 0);
        tick();
        checkOutput("empty_flush_done", flush_done, 1);
        checkOutput("empty_flush_valid2", out_valid, 0);
        tick();
        checkOutput("empty_flush_pulse", flush_done, 0);
        checkOutput("empty_flush_count", byte_count, 9);

        // Reset in the middle of a flush with 5 bits pending
        out_ready = 1'b0;
        applyStimulus(18'h00016, 5'd5, 1'b0);
        applyStimulus(18'h0, 5'd0, 1'b1);
        checkOutput("mid_valid", out_valid, 1);
        checkOutput("mid_data", out_data, 8'h0D);
        checkOutput("mid_last", out_last, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_last", out_last, 0);
        checkOutput("mid_rst_done", flush_done, 0);
        checkOutput("mid_rst_data", out_data, 0);
        checkOutput("mid_rst_count", byte_count, 0);
        checkOutput("mid_rst_len_error", len_error, 0);
        #3 reset_n = 1'b1;
        tick();
        checkOutput("mid_rel_in_ready", in_ready, 1);
        checkOutput("mid_rel_done", flush_done, 0);
        checkOutput("mid_rel_valid", out_valid, 0);

        // 65536 transfers wrap the byte counter
        out_ready = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            applyStimulus(18'h00001, 5'd8, 1'b0);
        end
        checkOutput("wrap_pre_count", byte_count, 16'hFFFF);
        checkOutput("wrap_pre_data", out_data, 8'h80);
        tick();
        checkOutput("wrap_count", byte_count, 16'h0000);
        checkOutput("wrap_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/huffman_bit_packer.md
HUFFMAN_BIT_PACKER -- requirements
Module: huffman_bit_packer

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port data_in, input, 18, encoded code; valid bits right-aligned in data_in[valid_bits-1:0].
REQ-004 SHALL have port valid_bits, input, 5, count of valid code bits; 0 = no word this cycle.
REQ-005 SHALL have port in_ready, output, 1, packer can accept a word this cycle.
REQ-006 SHALL have port flush, input, 1, single-cycle request to drain and pad the final byte.
REQ-007 SHALL have port out_data, output, 8, packed byte.
REQ-008 SHALL have port out_valid, output, 1, out_data is valid.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts out_data.
REQ-010 SHALL have port out_last, output, 1, current byte is the final byte of a flush.
REQ-011 SHALL have port flush_done, output, 1, one-cycle pulse when the flush completes.
REQ-012 SHALL have port byte_count, output, 16, total bytes transferred since reset; wraps 0xFFFF->0x0000.
REQ-013 SHALL have port len_error, output, 1, sticky flag set by a valid_bits value of 19..31.

Function
REQ-014 SHALL hold a 32-bit bit buffer and a 6-bit fill count (0..32).
REQ-015 SHALL accept a word when valid_bits is in 1..18 and in_ready=1; in_ready SHALL be 1 iff state=RUN and fill count <=14.
REQ-016 SHALL append accepted bits MSB-first: buffer bit (fill+i) = data_in bit (valid_bits-1-i), for i = 0..valid_bits-1.
REQ-017 SHALL drive out_data = buffer[7:0]; out_valid SHALL be 1 when fill >=8, or when state=FLUSH and fill is 1..7.
REQ-018 SHALL complete a byte transfer on out_valid && out_ready, then shift the buffer right by 8 and reduce fill by min(8, fill).
REQ-019 SHALL zero-pad the unused high bits of a partial final byte.
REQ-020 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL process an accept and a byte transfer in the same cycle: new fill = fill - drained + valid_bits, with appended bits placed after the shift.
REQ-022 SHALL ignore a word with valid_bits >18, leave buffer and fill unchanged, and set len_error until reset.
REQ-023 SHALL use FSM states RUN and FLUSH. RUN -> FLUSH on flush=1, and a word accepted in that same cycle is included. FLUSH -> RUN on the cycle the last byte transfers, or immediately when fill=0.
REQ-024 SHALL drive out_last=1 only on the byte that empties the buffer in FLUSH.
REQ-025 SHALL pulse flush_done for one cycle on the FLUSH->RUN transition; with fill=0 at entry, no byte is emitted and flush_done follows one cycle after flush.
REQ-026 SHALL ignore flush while in FLUSH.
REQ-027 SHALL increment byte_count by 1 on each transferred byte.

Reset
REQ-028 SHALL on reset_n=0 asynchronously clear buffer, fill, byte_count and len_error, enter state RUN, and drive out_valid=0, out_last=0, flush_done=0, out_data=0x00.
REQ-029 SHALL on reset mid-flush discard all pending bits without emitting out_last or flush_done.
REQ-030 SHALL assert in_ready=1 on the first clock edge after reset_n deasserts.

Structure
REQ-031 SHALL take the constants MAX_CODE_BITS=18, BUF_BITS=32 and ACCEPT_LIMIT=14, and the state enum {RUN, FLUSH}, from the shared package huffman_pkg.
REQ-032 SHALL be a single module with no sub-module; the bit-append shifter is inline logic.

Verification
REQ-033 SHALL cover: data_in=0x30, valid_bits=8, out_ready=1 -> out_data=0x0C, out_last=0, byte_count=1.
REQ-034 SHALL cover: 5'b10101, then 5'b11111, then flush -> bytes 0xF5, then 0x03 with out_last=1, then flush_done pulse.
REQ-035 SHALL cover: out_ready=0 with 18-bit words each cycle -> in_ready=0 after the first accept, no bits lost, out_data stable; then out_ready=1 -> bytes drain in order.
REQ-036 SHALL cover: valid_bits=20 -> len_error=1, fill unchanged, next legal word packs correctly.
REQ-037 SHALL cover: flush with an empty buffer -> no out_valid, flush_done one cycle later; then reset_n=0 mid-flush with 5 bits pending -> all outputs at reset values, no out_last.
REQ-038 SHALL cover: 65 536 byte transfers -> byte_count wraps to 0x0000.
